// File: rtl/bcd_time_counter.sv
// Time-of-day generator: 100 Hz prescaler feeding a packed BCD HH:MM:SS.cc chain with day wrap,
// run/pause and validated preset load. Optional alarm comparator enabled by BCD_TIME_ALARM_EN.
module bcd_time_counter #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iRUN,
    input  logic        iLOAD,
    input  logic [31:0] iLOAD_TIME,
    input  logic [23:0] iALARM_TIME,
    input  logic        iALARM_ARM,
    input  logic        iALARM_ACK,
    output logic [31:0] oTIME,
    output logic        oTICK,
    output logic        oROLLOVER,
    output logic        oLOAD_ERR,
    output logic        oALARM
);
    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

    logic [PW-1:0] r_pcnt;
    logic [31:0]   r_time;
    logic          r_tick;
    logic          r_rollover;
    logic          r_load_err;

    logic          w_step;
    logic [5:0]    w_dmax;
    logic [23:0]   w_low_inc;
    logic [7:0]    w_hours_inc;
    logic          w_hr_carry;
    logic          w_hour_wrap;
    logic          w_rollover;
    logic [7:0]    w_digit_ok;
    logic          w_load_ok;
    logic [31:0]   w_time_next;
    logic          w_update;

    assign w_step = iRUN && (r_pcnt == PCNT_LAST);

    // Digits C0..M1: each carry-in is the AND of all lower digits being at their limit,
    // computed directly rather than rippled so there is no chained net.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            localparam logic [3:0] LIM  = (gi == 3 || gi == 5) ? 4'd5 : 4'd9;
            localparam logic [5:0] MASK = 6'((1 << gi) - 1);
            logic [3:0] w_d;
            logic       w_cin;
            assign w_d                  = r_time[4*gi +: 4];
            assign w_dmax[gi]           = (w_d == LIM);
            assign w_cin                = ((w_dmax & MASK) == MASK);
            assign w_low_inc[4*gi +: 4] = !w_cin ? w_d : (w_dmax[gi] ? 4'd0 : w_d + 4'd1);
        end
    endgenerate

    assign w_hr_carry  = &w_dmax;
    assign w_hour_wrap = (r_time[31:28] == 4'd2) && (r_time[27:24] == 4'd3);
    assign w_rollover  = w_hr_carry && w_hour_wrap;

    always_comb begin
        w_hours_inc = r_time[31:24];
        if (w_hr_carry) begin
            if (w_hour_wrap)
                w_hours_inc = 8'h00;
            else if (r_time[27:24] == 4'd9)
                w_hours_inc = {r_time[31:28] + 4'd1, 4'd0};
            else
                w_hours_inc = {r_time[31:28], r_time[27:24] + 4'd1};
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_load_chk
            assign w_digit_ok[gi] = (iLOAD_TIME[4*gi +: 4] <= 4'd9);
        end
    endgenerate

    assign w_load_ok = (&w_digit_ok)
                    && (iLOAD_TIME[15:12] <= 4'd5)
                    && (iLOAD_TIME[23:20] <= 4'd5)
                    && (iLOAD_TIME[31:28] <= 4'd2)
                    && !((iLOAD_TIME[31:28] == 4'd2) && (iLOAD_TIME[27:24] > 4'd3));

    // A load request always swallows a coinciding step, accepted or not.
    always_comb begin
        w_time_next = r_time;
        w_update    = 1'b0;
        if (iLOAD) begin
            if (w_load_ok) begin
                w_time_next = iLOAD_TIME;
                w_update    = 1'b1;
            end
        end else if (w_step) begin
            w_time_next = {w_hours_inc, w_low_inc};
            w_update    = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_pcnt     <= '0;
            r_time     <= 32'h0;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_time     <= w_time_next;
            r_tick     <= !iLOAD && w_step;
            r_rollover <= !iLOAD && w_step && w_rollover;
            r_load_err <= iLOAD && !w_load_ok;
            if (iLOAD) begin
                if (w_load_ok)
                    r_pcnt <= '0;
            end else if (iRUN) begin
                r_pcnt <= w_step ? '0 : r_pcnt + PW'(1);
            end
        end
    end

`ifdef BCD_TIME_ALARM_EN
    logic r_alarm;
    logic w_alarm_hit;

    assign w_alarm_hit = iALARM_ARM && w_update && (w_time_next == {iALARM_TIME, 8'h00});

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            r_alarm <= 1'b0;
        else if (w_alarm_hit)
            r_alarm <= 1'b1;
        else if (iALARM_ACK || !iALARM_ARM)
            r_alarm <= 1'b0;
    end

    assign oALARM = r_alarm;
`else
    logic w_unused_alarm;
    assign w_unused_alarm = ^{iALARM_TIME, iALARM_ARM, iALARM_ACK, w_update};
    assign oALARM = 1'b0;
`endif

    assign oTIME     = r_time;
    assign oTICK     = r_tick;
    assign oROLLOVER = r_rollover;
    assign oLOAD_ERR = r_load_err;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter (DIV=10): vector table, directed corner sequences, and random
// run/load traffic checked against a model that keeps time as an integer count of hundredths.
module tb_bcd_time_counter;
    localparam int DIV = 10;
    localparam int DAY = 8640000;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iRUN = 1'b0;
    logic        iLOAD = 1'b0;
    logic [31:0] iLOAD_TIME = 32'h0;
    logic [23:0] iALARM_TIME = 24'h0;
    logic        iALARM_ARM = 1'b0;
    logic        iALARM_ACK = 1'b0;
    logic [31:0] oTIME;
    logic        oTICK, oROLLOVER, oLOAD_ERR, oALARM;

    bcd_time_counter #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iRUN(iRUN), .iLOAD(iLOAD), .iLOAD_TIME(iLOAD_TIME),
        .iALARM_TIME(iALARM_TIME), .iALARM_ARM(iALARM_ARM), .iALARM_ACK(iALARM_ACK),
        .oTIME(oTIME), .oTICK(oTICK), .oROLLOVER(oROLLOVER), .oLOAD_ERR(oLOAD_ERR), .oALARM(oALARM)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;
    int m_time = 0;
    int m_cnt = 0;
    bit m_alarm = 1'b0;

`ifdef BCD_TIME_ALARM_EN
    localparam logic ALARM_EXP = 1'b1;
`else
    localparam logic ALARM_EXP = 1'b0;
`endif

    function automatic logic [31:0] to_bcd(input int t);
        int c, s, m, h;
        c = t % 100;
        s = (t / 100) % 60;
        m = (t / 6000) % 60;
        h = t / 360000;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic bit bcd_valid(input logic [31:0] b, output int t);
        int d[8];
        int h, m, s, c;
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d[i] = int'(b[4*i +: 4]);
            if (d[i] > 9) ok = 1'b0;
        end
        h = d[7] * 10 + d[6];
        m = d[5] * 10 + d[4];
        s = d[3] * 10 + d[2];
        c = d[1] * 10 + d[0];
        if (h >= 24 || m >= 60 || s >= 60) ok = 1'b0;
        t = ((h * 60 + m) * 60 + s) * 100 + c;
        return ok;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; the model advances and every output is compared.
    task automatic drive_cycle(input logic ld, input logic [31:0] lt, input logic run);
        bit e_tick, e_roll, e_err, upd, ok;
        int t;
        logic [31:0] nb;
        iLOAD = ld;
        iLOAD_TIME = lt;
        iRUN = run;
        @(posedge iCLK);
        #1;
        e_tick = 0; e_roll = 0; e_err = 0; upd = 0;
        if (ld) begin
            ok = bcd_valid(lt, t);
            if (ok) begin
                m_time = t;
                m_cnt = 0;
                upd = 1;
            end else begin
                e_err = 1;
            end
        end else if (run) begin
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                e_tick = 1;
                e_roll = (m_time == DAY - 1);
                m_time = (m_time + 1) % DAY;
                upd = 1;
            end else begin
                m_cnt++;
            end
        end
        nb = to_bcd(m_time);
`ifdef BCD_TIME_ALARM_EN
        if (upd && iALARM_ARM && nb[31:8] == iALARM_TIME && nb[7:0] == 8'h00)
            m_alarm = 1'b1;
        else if (iALARM_ACK || !iALARM_ARM)
            m_alarm = 1'b0;
`endif
        check("cycle", {28'h0, oTIME, oTICK, oROLLOVER, oLOAD_ERR, oALARM},
                       {28'h0, nb, e_tick, e_roll, e_err, m_alarm});
        iLOAD = 1'b0;
    endtask

    task automatic wait_tick(input int max_cyc, output int n);
        n = 0;
        do begin
            drive_cycle(1'b0, 32'h0, 1'b1);
            n++;
        end while (!oTICK && n < max_cyc);
        if (!oTICK) n = 0;
    endtask

    typedef struct {
        logic [31:0] ld;
        bit          err;
        logic [31:0] nxt;
        bit          roll;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] prev, frozen, lt;
        bit ld, rn;
        int sel;

        vecs[0] = '{32'h23595999, 1'b0, 32'h00000000, 1'b1};
        vecs[1] = '{32'h24000000, 1'b1, 32'h0, 1'b0};
        vecs[2] = '{32'h1260000A, 1'b1, 32'h0, 1'b0};
        vecs[3] = '{32'h09595999, 1'b0, 32'h10000000, 1'b0};
        vecs[4] = '{32'h19595999, 1'b0, 32'h20000000, 1'b0};
        vecs[5] = '{32'h20595999, 1'b0, 32'h21000000, 1'b0};
        vecs[6] = '{32'h23A00000, 1'b1, 32'h0, 1'b0};
        vecs[7] = '{32'h12345678, 1'b0, 32'h12345679, 1'b0};
        vecs[8] = '{32'h09595909, 1'b0, 32'h09595910, 1'b0};
        vecs[9] = '{32'h00005999, 1'b0, 32'h00010000, 1'b0};

        // Reset state and first step
        repeat (3) @(posedge iCLK);
        #1;
        check("reset_outputs", {28'h0, oTIME, oTICK, oROLLOVER, oLOAD_ERR, oALARM}, 64'h0);
        iRUN = 1'b1;
        iRST_N = 1'b1;
        for (int i = 1; i <= DIV; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b1);
            if (i < DIV) check("pre_first_step", {31'h0, oTIME, oTICK}, 64'h0);
        end
        check("first_step", {31'h0, oTIME, oTICK}, {31'h0, 32'h00000001, 1'b1});
        $display("first step time=%h tick=%b", oTIME, oTICK);
        wait_tick(DIV + 2, n);
        check("tick_period", 64'(n), 64'(DIV));

        // Table of loads: validity, retained value on reject, and value after one step
        prev = to_bcd(m_time);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, vecs[i].ld, 1'b1);
            check("load_err", 64'(oLOAD_ERR), 64'(vecs[i].err));
            check("load_time", 64'(oTIME), 64'(vecs[i].err ? prev : vecs[i].ld));
            if (!vecs[i].err) begin
                wait_tick(DIV + 2, n);
                check("load_to_step", 64'(n), 64'(DIV));
                check("step_time", 64'(oTIME), 64'(vecs[i].nxt));
                check("step_roll", 64'(oROLLOVER), 64'(vecs[i].roll));
                prev = vecs[i].nxt;
            end
            $display("vec %0d load=%h err=%b time=%h roll=%b", i, vecs[i].ld, oLOAD_ERR, oTIME, oROLLOVER);
        end

        // Load on the step cycle: value appears, tick suppressed
        for (int k = 0; k < DIV && m_cnt != DIV - 1; k++) drive_cycle(1'b0, 32'h0, 1'b1);
        drive_cycle(1'b1, 32'h11111111, 1'b1);
        check("load_on_step_time", 64'(oTIME), 64'h11111111);
        check("load_on_step_tick", 64'(oTICK), 64'h0);
        wait_tick(DIV + 2, n);
        check("load_on_step_next", 64'(n), 64'(DIV));
        $display("load on step cycle time=%h", oTIME);

        // Pause mid-count for 37 cycles
        for (int k = 0; k < DIV && m_cnt != 4; k++) drive_cycle(1'b0, 32'h0, 1'b1);
        frozen = oTIME;
        for (int k = 0; k < 37; k++) drive_cycle(1'b0, 32'h0, 1'b0);
        check("pause_time", 64'(oTIME), 64'(frozen));
        wait_tick(DIV + 2, n);
        check("resume_cycles", 64'(n), 64'(DIV - 4));
        $display("pause resumed after %0d cycles time=%h", n, oTIME);

        // Dropping iRUN exactly on the step cycle
        for (int k = 0; k < DIV && m_cnt != DIV - 1; k++) drive_cycle(1'b0, 32'h0, 1'b1);
        frozen = oTIME;
        drive_cycle(1'b0, 32'h0, 1'b0);
        check("pause_on_step_tick", {31'h0, oTIME, oTICK}, {31'h0, frozen, 1'b0});
        drive_cycle(1'b0, 32'h0, 1'b1);
        check("pause_on_step_resume", 64'(oTICK), 64'h1);

        // Alarm at 00:00:01.00
        iALARM_TIME = 24'h000001;
        iALARM_ARM = 1'b1;
        drive_cycle(1'b1, 32'h00000099, 1'b1);
        wait_tick(DIV + 2, n);
        check("alarm_set", {31'h0, oTIME, oALARM}, {31'h0, 32'h00000100, ALARM_EXP});
        repeat (5) drive_cycle(1'b0, 32'h0, 1'b1);
        check("alarm_hold", 64'(oALARM), 64'(ALARM_EXP));
        iALARM_ACK = 1'b1;
        drive_cycle(1'b0, 32'h0, 1'b1);
        iALARM_ACK = 1'b0;
        check("alarm_ack", 64'(oALARM), 64'h0);
        $display("alarm sequence done alarm=%b", oALARM);
        iALARM_ARM = 1'b0;
        drive_cycle(1'b0, 32'h0, 1'b1);

        // Random run/load traffic
        for (int i = 0; i < 800; i++) begin
            ld = ($urandom_range(0, 19) == 0);
            rn = ($urandom_range(0, 9) != 0);
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      lt = $urandom;
            else if (sel == 1) lt = to_bcd(int'($urandom_range(0, DAY - 1)));
            else               lt = to_bcd(DAY - int'($urandom_range(1, 30)));
            drive_cycle(ld, lt, rn);
            if (ld) $display("rand load=%h err=%b time=%h", lt, oLOAD_ERR, oTIME);
        end

        // Asynchronous reset mid-count
        drive_cycle(1'b1, 32'h12345678, 1'b1);
        for (int k = 0; k < DIV && m_cnt != 5; k++) drive_cycle(1'b0, 32'h0, 1'b1);
        #2;
        iRST_N = 1'b0;
        #1;
        check("async_reset", {28'h0, oTIME, oTICK, oROLLOVER, oLOAD_ERR, oALARM}, 64'h0);
        @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
        m_time = 0;
        m_cnt = 0;
        m_alarm = 1'b0;
        wait_tick(DIV + 2, n);
        check("post_reset_step", {31'h0, oTIME, 1'b0}, {31'h0, 32'h00000001, 1'b0});
        check("post_reset_cycles", 64'(n), 64'(DIV));
        $display("reset mid-count then step time=%h", oTIME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
